// File: rtl/csi2_pkg.sv
// -----------------------------------------------------------------------------
// csi2_pkg
// Shared definitions for the CSI-2 D-PHY HS lane aligner:
//   byte_t         - one HS lane byte
//   SYNC_BYTE      - default SoT sync byte (0xB8, LSB received first)
//   align_state_t  - global aligner FSM states
//   hamming1()     - true when two bytes differ in exactly one bit
// -----------------------------------------------------------------------------
package csi2_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t SYNC_BYTE = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HUNT,
        ST_ALIGN,
        ST_STREAM,
        ST_ERR
    } align_state_t;

    function automatic logic hamming1(input byte_t a, input byte_t b);
        byte_t x;
        x = a ^ b;
        // exactly one bit set: non-zero and a power of two
        return (x != '0) && ((x & (x - 8'd1)) == '0);
    endfunction

endpackage

// File: rtl/csi2_lane_sync.sv
// -----------------------------------------------------------------------------
// csi2_lane_sync
// One HS lane: previous-byte register, SoT sync offset search over the
// 16-bit window {cur, prev}, lock flag/offset, and a small deskew FIFO.
// Optional feature macro: HS_ALIGN_SOFT_SYNC_EN (accept Hamming-distance-1
// sync windows when no exact match exists at any offset).
// Ports:
//   clk, rst   - byte clock, synchronous active-high reset
//   clear      - flush lane state and FIFO (HS inactive or deskew timeout)
//   hunt_en    - offset search permitted this cycle
//   in_valid   - in_byte carries a new gearbox byte
//   in_byte    - unaligned byte, LSB received first
//   pop        - pop one aligned byte (common to all lanes)
//   locked     - lane has found its sync offset
//   hit        - sync found this cycle (lock takes effect next cycle)
//   head       - aligned byte presented for the current pop
// -----------------------------------------------------------------------------
module csi2_lane_sync
    import csi2_pkg::*;
#(
    parameter byte_t       SYNC  = SYNC_BYTE,
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       hunt_en,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    input  logic       pop,
    output logic       locked,
    output logic       hit,
    output logic [7:0] head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    byte_t          prev;
    logic [15:0]    window;
    logic [2:0]     off;
    logic [2:0]     off_sel;
    logic           found;
    byte_t          aligned;
    logic           push;
    logic           bypass;
    byte_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign window = {in_byte, prev};

    // Lowest exact offset first; soft matches only considered if no exact hit.
    always_comb begin
        found   = 1'b0;
        off_sel = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (!found && (window[k +: 8] == SYNC)) begin
                found   = 1'b1;
                off_sel = 3'(k);
            end
        end
`ifdef HS_ALIGN_SOFT_SYNC_EN
        for (int unsigned k = 0; k < 8; k++) begin
            if (!found && hamming1(window[k +: 8], SYNC)) begin
                found   = 1'b1;
                off_sel = 3'(k);
            end
        end
`endif
    end

    assign hit     = hunt_en && in_valid && !locked && found;
    assign aligned = window[off +: 8];
    assign push    = locked && in_valid;
    // Empty FIFO with simultaneous push/pop: the byte passes straight through,
    // so the last-locking lane adds no latency.
    assign bypass  = push && pop && (count == '0);
    assign head    = (count == '0) ? aligned : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !bypass) begin
            mem[wr_ptr] <= aligned;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            prev   <= '0;
            locked <= 1'b0;
            off    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (in_valid) begin
                prev <= in_byte;
            end
            if (hit) begin
                locked <= 1'b1;
                off    <= off_sel;
            end
            if (!bypass) begin
                if (push) begin
                    wr_ptr <= ptr_next(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_next(rd_ptr);
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/csi2_hs_lane_aligner.sv
// -----------------------------------------------------------------------------
// csi2_hs_lane_aligner
// Multi-lane D-PHY HS byte aligner: per-lane SoT sync search and lock,
// lane deskew, and emission of lane-aligned byte vectors with one valid.
// Optional feature macro: HS_ALIGN_SOFT_SYNC_EN (soft sync match, see
// csi2_lane_sync).
// Ports:
//   clk, rst   - byte clock, synchronous active-high reset
//   hs_active  - all lanes in HS mode
//   in_valid   - new gearbox byte on every lane
//   in_data    - unaligned bytes, lane n in [8n+7:8n]
//   out_valid  - out_data holds one aligned byte per lane
//   out_data   - aligned bytes, lane n in [8n+7:8n]
//   locked     - per-lane lock status
//   sync_err   - one-cycle pulse on deskew timeout
// -----------------------------------------------------------------------------
module csi2_hs_lane_aligner
    import csi2_pkg::*;
#(
    parameter int unsigned LANES    = 2,
    parameter byte_t       SYNC     = SYNC_BYTE,
    parameter int unsigned SKEW_MAX = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hs_active,
    input  logic               in_valid,
    input  logic [8*LANES-1:0] in_data,
    output logic               out_valid,
    output logic [8*LANES-1:0] out_data,
    output logic [LANES-1:0]   locked,
    output logic               sync_err
);

    align_state_t       state;
    align_state_t       state_nxt;
    logic [2:0]         skew_cnt;
    logic [LANES-1:0]   hit;
    logic [LANES-1:0]   lock_nxt;
    logic [8*LANES-1:0] heads;
    logic               any_lock;
    logic               all_lock;
    logic               hunt_en;
    logic               pop;
    logic               timeout;
    logic               clear;

    // Lock view including locks found this cycle, so simultaneous final
    // lock beats a timeout in the same cycle.
    assign lock_nxt = locked | hit;
    assign any_lock = |lock_nxt;
    assign all_lock = &lock_nxt;
    assign hunt_en  = (state == ST_HUNT) || (state == ST_ALIGN);
    assign pop      = hs_active && in_valid && (state == ST_STREAM);
    assign timeout  = hs_active && in_valid && (state == ST_ALIGN) && !all_lock &&
                      ((skew_cnt + 3'd1) == 3'(SKEW_MAX));
    assign clear    = !hs_active || timeout;

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        csi2_lane_sync #(
            .SYNC  (SYNC),
            .DEPTH (SKEW_MAX + 1)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .clear    (clear),
            .hunt_en  (hunt_en),
            .in_valid (in_valid),
            .in_byte  (in_data[8*n +: 8]),
            .pop      (pop),
            .locked   (locked[n]),
            .hit      (hit[n]),
            .head     (heads[8*n +: 8])
        );
    end

    always_comb begin
        state_nxt = state;
        if (!hs_active) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:   state_nxt = ST_HUNT;
                ST_HUNT: begin
                    if (all_lock)      state_nxt = ST_STREAM;
                    else if (any_lock) state_nxt = ST_ALIGN;
                end
                ST_ALIGN: begin
                    if (all_lock)     state_nxt = ST_STREAM;
                    else if (timeout) state_nxt = ST_ERR;
                end
                ST_STREAM: state_nxt = ST_STREAM;
                ST_ERR:    state_nxt = ST_ERR;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            skew_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sync_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= pop;
            sync_err  <= timeout;
            if (pop) begin
                out_data <= heads;
            end
            if (state != ST_ALIGN) begin
                skew_cnt <= '0;
            end else if (in_valid && hs_active) begin
                skew_cnt <= skew_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_csi2_hs_lane_aligner.sv
// -----------------------------------------------------------------------------
// tb_csi2_hs_lane_aligner
// Directed bench: u1 is a single-lane aligner, u2 a two-lane aligner with
// SKEW_MAX=3. Byte streams are pre-shifted by hand to place the sync byte
// at the wanted bit offset.
// -----------------------------------------------------------------------------
module tb_csi2_hs_lane_aligner;

    logic        clk = 1'b0;
    logic        rst;
    logic        hs1, iv1;
    logic [7:0]  d1;
    logic        ov1, se1;
    logic [7:0]  od1;
    logic [0:0]  lk1;
    logic        hs2, iv2;
    logic [15:0] d2;
    logic        ov2, se2;
    logic [15:0] od2;
    logic [1:0]  lk2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    csi2_hs_lane_aligner #(
        .LANES    (1),
        .SYNC     (8'hB8),
        .SKEW_MAX (3)
    ) u1 (
        .clk       (clk),
        .rst       (rst),
        .hs_active (hs1),
        .in_valid  (iv1),
        .in_data   (d1),
        .out_valid (ov1),
        .out_data  (od1),
        .locked    (lk1),
        .sync_err  (se1)
    );

    csi2_hs_lane_aligner #(
        .LANES    (2),
        .SYNC     (8'hB8),
        .SKEW_MAX (3)
    ) u2 (
        .clk       (clk),
        .rst       (rst),
        .hs_active (hs2),
        .in_valid  (iv2),
        .in_data   (d2),
        .out_valid (ov2),
        .out_data  (od2),
        .locked    (lk2),
        .sync_err  (se2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        hs1 = 1'b0; iv1 = 1'b0; d1 = 8'h00;
        hs2 = 1'b0; iv2 = 1'b0; d2 = 16'h0000;
        step(); step();
        check("rst_ov1", ov1, 0); check("rst_od1", od1, 0);
        check("rst_lk1", lk1, 0); check("rst_se1", se1, 0);
        check("rst_ov2", ov2, 0); check("rst_od2", od2, 0);
        check("rst_lk2", lk2, 0); check("rst_se2", se2, 0);
        rst = 1'b0;

        // single lane, sync at offset 3; stream 00 B8 12 34 56 78 shifted left 3
        hs1 = 1'b1; step();
        iv1 = 1'b1;
        d1 = 8'h00; step();
        d1 = 8'hC0; step();
        check("l1_pre_lock", lk1, 0);
        d1 = 8'h95; step();
        check("l1_locked", lk1, 1);
        check("l1_ov_lock_cycle", ov1, 0);
        d1 = 8'hA0; step();
        check("l1_ov_first", ov1, 1); check("l1_byte0", od1, 8'h12);
        d1 = 8'hB1; step();
        check("l1_byte1", od1, 8'h34);
        // two-cycle in_valid gap
        iv1 = 1'b0; step();
        check("gap_ov_a", ov1, 0);
        step();
        check("gap_ov_b", ov1, 0); check("gap_hold", od1, 8'h34);
        iv1 = 1'b1; d1 = 8'hC2; step();
        check("gap_ov_resume", ov1, 1); check("l1_byte2", od1, 8'h56);
        d1 = 8'h03; step();
        check("l1_byte3", od1, 8'h78);
        // hs_active dropped mid-packet with in_valid still high
        hs1 = 1'b0; d1 = 8'h5A; step();
        check("drop_ov", ov1, 0); check("drop_lk", lk1, 0);
        iv1 = 1'b0; step();
        check("idle_ov", ov1, 0);
        hs1 = 1'b1; step();
        // new burst, sync at offset 5; stream 00 B8 9A BC shifted left 5
        iv1 = 1'b1;
        d1 = 8'h00; step();
        d1 = 8'h00; step();
        d1 = 8'h57; step();
        check("b2_locked", lk1, 1);
        d1 = 8'h93; step();
        check("b2_ov", ov1, 1); check("b2_byte0", od1, 8'h9A);
        d1 = 8'h17; step();
        check("b2_byte1", od1, 8'hBC);
        // synchronous reset mid-stream
        rst = 1'b1; d1 = 8'h22; step();
        check("mid_rst_ov", ov1, 0); check("mid_rst_od", od1, 0);
        check("mid_rst_lk", lk1, 0); check("mid_rst_se", se1, 0);
        rst = 1'b0; iv1 = 1'b0; step();
        // 0xB9 at offset 0: soft-match only
        iv1 = 1'b1;
        d1 = 8'h00; step();
        d1 = 8'hB9; step();
        d1 = 8'h44; step();
`ifdef HS_ALIGN_SOFT_SYNC_EN
        check("soft_lk", lk1, 1);
        d1 = 8'h45; step();
        check("soft_ov", ov1, 1); check("soft_byte", od1, 8'h44);
`else
        check("soft_lk", lk1, 0);
        d1 = 8'h45; step();
        check("soft_ov", ov1, 0); check("soft_lk_hold", lk1, 0);
`endif
        hs1 = 1'b0; iv1 = 1'b0; step();

        // two lanes, lane 1 syncs one valid cycle after lane 0 (offset 0)
        hs2 = 1'b1; step();
        iv2 = 1'b1;
        d2 = 16'h0000; step();
        d2 = 16'h00B8; step();
        d2 = 16'hB8A0; step();
        check("dsk_lk_first", lk2, 2'b01);
        d2 = 16'hB0A1; step();
        check("dsk_lk_all", lk2, 2'b11); check("dsk_ov_pre", ov2, 0);
        d2 = 16'hB1A2; step();
        check("dsk_ov", ov2, 1); check("dsk_word0", od2, 16'hB0A0);
        d2 = 16'hB2A3; step();
        check("dsk_word1", od2, 16'hB1A1);

        // lane 1 never syncs: timeout after SKEW_MAX valid cycles
        hs2 = 1'b0; iv2 = 1'b0; step();
        check("to_idle_ov", ov2, 0); check("to_idle_lk", lk2, 0);
        hs2 = 1'b1; step();
        iv2 = 1'b1;
        d2 = 16'h0000; step();
        d2 = 16'h00B8; step();
        d2 = 16'h00C0; step();
        check("to_lk0", lk2, 2'b01);
        d2 = 16'h00C1; step();
        d2 = 16'h00C2; step();
        check("to_se_early", se2, 0); check("to_lk_early", lk2, 2'b01);
        d2 = 16'h00C3; step();
        check("to_se_pulse", se2, 1); check("to_lk_clear", lk2, 0);
        d2 = 16'hB8B8; step();
        check("to_se_once", se2, 0);
        d2 = 16'h1111; step();
        d2 = 16'h2222; step();
        check("err_no_lock", lk2, 0); check("err_no_ov", ov2, 0);

        // toggle hs_active, both lanes lock together (HUNT straight to STREAM)
        hs2 = 1'b0; iv2 = 1'b0; step();
        hs2 = 1'b1; step();
        iv2 = 1'b1;
        d2 = 16'hB8B8; step();
        d2 = 16'hE0D0; step();
        check("sim_lk", lk2, 2'b11);
        d2 = 16'hE1D1; step();
        check("sim_ov", ov2, 1); check("sim_word0", od2, 16'hE0D0);
        hs2 = 1'b0; iv2 = 1'b0; step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/csi2_hs_lane_aligner.md
# csi2_hs_lane_aligner

Parametrised multi-lane D-PHY high-speed byte aligner. It sits between the per-lane 1:8 input gearboxes (fed by the IB/IFS1P3 input-register primitives) and the CSI-2 packet layer. Per lane, it finds the SoT sync byte 0xB8 at any bit offset, locks that offset, and deskews the lanes with small per-lane FIFOs. It then emits lane-aligned byte vectors with a single valid.

## Interface
Parameters:
- `LANES`, 2: number of HS data lanes, 1..4.
- `SYNC`, 8'hB8: SoT sync byte, compared LSB-first.
- `SKEW_MAX`, 3: maximum lane-to-lane lock skew in valid cycles, 1..7. It also sets the deskew FIFO depth to SKEW_MAX+1.

Ports:
- `clk`, in, 1: byte clock, the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `hs_active`, in, 1: high while all lanes are in HS mode, from the LP detector.
- `in_valid`, in, 1: all `in_data` lanes carry a new gearbox byte. Common to all lanes.
- `in_data`, in, 8*LANES: unaligned bytes. Lane n is in [8n+7:8n]; the bit received first is the LSB.
- `out_valid`, out, 1: `out_data` holds one aligned byte per lane.
- `out_data`, out, 8*LANES: aligned bytes, lane n in [8n+7:8n].
- `locked`, out, LANES: per-lane lock status.
- `sync_err`, out, 1: one-cycle pulse on deskew timeout.

## Operation
- Per lane, `prev` is the last valid byte. The search window is {cur, prev} (16 bits), with prev in the LSBs.
- Offset search: while hunting, the lane takes the lowest k in 0..7 with window[k+7:k]==SYNC.
  - On a match the lane stores k and sets `locked[n]`.
  - The sync byte itself is never output.
- After lock, every valid cycle the lane pushes window[k+7:k] into its deskew FIFO (depth SKEW_MAX+1).
- Global FSM states:
  - IDLE: `hs_active` low. Lanes and FIFOs are cleared and `locked` is 0.
  - HUNT: `hs_active` high and no lane locked.
  - ALIGN: at least one lane locked, not all.
  - STREAM: all lanes locked.
  - ERR: after a timeout, waits for `hs_active` low.
- Transitions:
  - IDLE to HUNT when `hs_active` rises.
  - HUNT to ALIGN on the first lock.
  - ALIGN to STREAM when the last lane locks.
  - ALIGN to ERR when the skew counter reaches SKEW_MAX valid cycles after the first lock and not all lanes are locked. This pulses `sync_err`, flushes the FIFOs and clears `locked`.
  - HUNT to STREAM directly if all lanes lock in the same cycle.
  - Any state to IDLE when `hs_active` is low. This takes priority over every other event in that cycle.
- In STREAM, every `in_valid` cycle all FIFOs pop simultaneously into `out_data`. Because pushes are common, lane occupancy differences stay constant, so the FIFOs never overflow or underflow.
- `in_valid` low: no push, no pop, and the skew counter holds.

## Timing
- Reset values: all outputs 0, FSM IDLE, FIFOs empty, skew counter 0.
- Lock latency: `locked[n]` is high one cycle after the valid cycle whose window contains SYNC.
- Data latency: the first aligned post-sync byte of the last-locking lane appears on `out_data` one cycle after that lane's lock cycle. Earlier-locking lanes output their byte from the same transmitted position at the same time.
- `out_valid` is a registered copy of (STREAM and `in_valid`). It is never high outside STREAM.
- `hs_active` falling: `out_valid` is 0 from the next cycle, and no partial FIFO contents are output.
- `rst` mid-stream: the next cycle matches the reset values exactly.

## Configuration
- `HS_ALIGN_SOFT_SYNC_EN` defined: a window at Hamming distance 1 from SYNC is also accepted. An exact match at any offset takes priority over a soft match, and the lowest offset wins within each class.
- Not defined: only exact matches lock.

## Structure
- Shared package `csi2_pkg` holds the FSM state enum, the `SYNC_BYTE` constant and the `byte_t` typedef.
- Sub-module `csi2_lane_sync`, one instance per lane, holds the prev register, offset search, lock flag and deskew FIFO. The top holds the FSM and the skew counter.

## Test plan
- Single lane (LANES=1), sync at offset 3: stream …, 0xC0, 0x05 (0xB8<<3 split), then payload 0x12 → `locked`=1 and `out_data`=0x12-aligned bytes, with `out_valid` starting one cycle later.
- LANES=2, lane 1 sync one valid cycle after lane 0, payloads 0xA0,0xA1 / 0xB0,0xB1 → `out_data`=16'hB0A0 then 16'hB1A1 on the same cycles.
- LANES=2, lane 1 never syncs, SKEW_MAX=3 → `sync_err` pulses 3 valid cycles after lane 0 locks, `locked`=0, FSM in ERR until `hs_active` toggles.
- `in_valid` gaps of 2 cycles during STREAM → no bytes lost or duplicated, and `out_valid` follows `in_valid` delayed by one cycle.
- `hs_active` dropped mid-packet, then a new burst → first burst truncated, second burst aligned correctly at a new offset.
- Window 0xB9 at offset 0 → locks only with `HS_ALIGN_SOFT_SYNC_EN` defined; without it the lane stays in HUNT.
